// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the fetch-side control of the MIPS pipeline:
// the opcodes the fetch sequencer must recognise, the fetch state encoding,
// the bubble word and the sequential PC increment.
package mips_ctrl_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    localparam logic [5:0]  OP_BEQ   = 6'h04;

    localparam logic [31:0] NOP_WORD = 32'h0;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_WAIT  = 2'd2
    } fetch_state_t;

    // Loads and stores share one stall window, so decode them together
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/fetch_stall_ctrl_stall_counter.sv
// stall_counter
// Loadable 4-bit down-counter shared by the MEM_WAIT and BR_WAIT windows.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (count -> 0)
//   i_load      load i_load_val (wins over i_dec)
//   i_load_val  value loaded when a wait window opens
//   i_dec       decrement by one; count holds when neither load nor dec
//   o_last      count is 1, i.e. this is the final cycle of the window
module stall_counter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_last
);

    logic [3:0] r_cnt;

    // Never wraps below zero, so a stray decrement after the window closes is harmless
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_last = (r_cnt == 4'd1);

endmodule

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl
// Clocked fetch sequencer between the PC register and instruction memory.
// Each cycle it decides whether the PC advances and whether the fetched word
// or a NOP bubble is passed to decode. Loads/stores get a fixed bubble window,
// a BEQ holds fetch until it is resolved or its wait times out.
// Ports:
//   i_clk              clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_instr_in         word read from instruction memory at current PC
//   i_stall_ext        external freeze (data memory busy), highest priority
//   i_branch_resolved  one-cycle pulse: pending BEQ outcome known
//   i_branch_taken     BEQ outcome, valid with i_branch_resolved
//   o_pc_write         PC register load enable
//   o_pc_addend        sequential increment (4 when advancing, else 0)
//   o_pc_sel_branch    select branch target as next PC
//   o_instr_out        word to decode, or NOP bubble
//   o_br_timeout_err   sticky flag: a branch wait expired
//   o_stall_cycles     saturating count of bubble cycles
module fetch_stall_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_STALL_CYCLES = 2,
    parameter int BR_TIMEOUT       = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr_in,
    input  logic        i_stall_ext,
    input  logic        i_branch_resolved,
    input  logic        i_branch_taken,
    output logic        o_pc_write,
    output logic [31:0] o_pc_addend,
    output logic        o_pc_sel_branch,
    output logic [31:0] o_instr_out,
    output logic        o_br_timeout_err,
    output logic [15:0] o_stall_cycles
);

    localparam logic [3:0] LP_MEM_LOAD = 4'(MEM_STALL_CYCLES);
    localparam logic [3:0] LP_BR_LOAD  = 4'(BR_TIMEOUT);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic         r_br_timeout_err;
    logic [15:0]  r_stall_cycles;

    logic [5:0]   w_opcode;
    logic         w_cnt_load;
    logic [3:0]   w_cnt_load_val;
    logic         w_cnt_dec;
    logic         w_cnt_last;
    logic         w_set_err;
    logic         w_bubble;

    assign w_opcode = i_instr_in[31:26];

    stall_counter u_stall_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_last     (w_cnt_last)
    );

    // Zero-latency decision on the current fetch. Reset and stall_ext both
    // force every output low; stall_ext also leaves state and count untouched,
    // which means a branch_resolved pulse arriving under stall_ext is lost.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_addend     = 32'd0;
        o_pc_sel_branch = 1'b0;
        o_instr_out     = NOP_WORD;
        w_next_state    = r_state;
        w_cnt_load      = 1'b0;
        w_cnt_load_val  = 4'd0;
        w_cnt_dec       = 1'b0;
        w_set_err       = 1'b0;

        if (i_rst_n && !i_stall_ext) begin
            case (r_state)
                RUN: begin
                    o_pc_write  = 1'b1;
                    o_pc_addend = PC_STEP;
                    o_instr_out = i_instr_in;
                    if (is_mem_op(w_opcode)) begin
                        w_next_state   = MEM_WAIT;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = LP_MEM_LOAD;
                    end else if (w_opcode == OP_BEQ) begin
                        w_next_state   = BR_WAIT;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = LP_BR_LOAD;
                    end
                end
                MEM_WAIT: begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_last) begin
                        w_next_state = RUN;
                    end
                end
                BR_WAIT: begin
                    // Resolution wins over a timeout landing on the same cycle
                    if (i_branch_resolved) begin
                        o_pc_write      = 1'b1;
                        o_pc_sel_branch = i_branch_taken;
                        o_pc_addend     = i_branch_taken ? 32'd0 : PC_STEP;
                        w_next_state    = RUN;
                    end else begin
                        w_cnt_dec = 1'b1;
                        if (w_cnt_last) begin
                            o_pc_write   = 1'b1;
                            o_pc_addend  = PC_STEP;
                            w_set_err    = 1'b1;
                            w_next_state = RUN;
                        end
                    end
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    // Any cycle out of reset where decode is not fed the fetched word is a bubble
    assign w_bubble = i_rst_n && (i_stall_ext || (r_state != RUN));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= RUN;
            r_br_timeout_err <= 1'b0;
            r_stall_cycles   <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_set_err) begin
                r_br_timeout_err <= 1'b1;
            end
            if (w_bubble && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign o_br_timeout_err = r_br_timeout_err;
    assign o_stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl
// Table-driven vectors, hand-written corner sequences and randomized traffic
// for fetch_stall_ctrl, checked against a behavioural model that tracks the
// number of bubbles still owed and how long a branch has been waiting.
module tb_fetch_stall_ctrl;

    localparam int MEM = 2;
    localparam int BRT = 4;

    localparam logic [31:0] W_ADD = 32'h00221820;
    localparam logic [31:0] W_LW  = 32'h8C220004;
    localparam logic [31:0] W_SW  = 32'hAC220004;
    localparam logic [31:0] W_BEQ = 32'h10220003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        ext;
    logic        res;
    logic        taken;
    logic        pcWrite;
    logic [31:0] pcAddend;
    logic        pcSel;
    logic [31:0] instrOut;
    logic        brErr;
    logic [15:0] stallCycles;

    always #5 clk = ~clk;

    fetch_stall_ctrl #(
        .MEM_STALL_CYCLES (MEM),
        .BR_TIMEOUT       (BRT)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_instr_in        (instr),
        .i_stall_ext       (ext),
        .i_branch_resolved (res),
        .i_branch_taken    (taken),
        .o_pc_write        (pcWrite),
        .o_pc_addend       (pcAddend),
        .o_pc_sel_branch   (pcSel),
        .o_instr_out       (instrOut),
        .o_br_timeout_err  (brErr),
        .o_stall_cycles    (stallCycles)
    );

    int checks = 0;
    int errors = 0;

    // Model state: bubbles still owed to a load/store, whether a branch is
    // outstanding and for how many unresolved cycles it has waited.
    int          mMemLeft;
    bit          mBrPending;
    int          mBrElapsed;
    bit          mErr;
    int          mStalls;
    bit          ePcw;
    logic [31:0] eAdd;
    bit          eSel;
    logic [31:0] eInstr;

    typedef struct {
        logic [31:0] ins;
        bit          ext;
        bit          res;
        bit          tk;
        bit          pcw;
        logic [31:0] add;
        bit          sel;
        logic [31:0] out;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMemLeft   = 0;
        mBrPending = 0;
        mBrElapsed = 0;
        mErr       = 0;
        mStalls    = 0;
    endtask

    task automatic modelStep(input logic [31:0] ins, input bit e, input bit r, input bit tk);
        bit bubble;
        bubble = 1;
        ePcw   = 0;
        eAdd   = 32'd0;
        eSel   = 0;
        eInstr = 32'd0;
        if (e) begin
            bubble = 1;
        end else if (mMemLeft > 0) begin
            mMemLeft--;
        end else if (mBrPending) begin
            if (r) begin
                ePcw       = 1;
                eSel       = tk;
                eAdd       = tk ? 32'd0 : 32'd4;
                mBrPending = 0;
            end else begin
                mBrElapsed++;
                if (mBrElapsed == BRT) begin
                    ePcw       = 1;
                    eAdd       = 32'd4;
                    mErr       = 1;
                    mBrPending = 0;
                end
            end
        end else begin
            bubble = 0;
            ePcw   = 1;
            eAdd   = 32'd4;
            eInstr = ins;
            if (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B) begin
                mMemLeft = MEM;
            end else if (ins[31:26] == 6'h04) begin
                mBrPending = 1;
                mBrElapsed = 0;
            end
        end
        if (bubble && mStalls < 65535) mStalls++;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input bit e, input bit r, input bit tk);
        @(negedge clk);
        instr = ins;
        ext   = e;
        res   = r;
        taken = tk;
        #1;
    endtask

    // Compares registered outputs against the model, advances the model with
    // the applied inputs, compares the combinational outputs, then clocks.
    task automatic verifyCycle(input bit useModelOutputs);
        checkOutput("stall_cycles", {16'd0, stallCycles}, 32'(mStalls));
        checkOutput("br_timeout_err", {31'd0, brErr}, {31'd0, mErr});
        modelStep(instr, ext, res, taken);
        if (useModelOutputs) begin
            checkOutput("pc_write", {31'd0, pcWrite}, {31'd0, ePcw});
            checkOutput("pc_addend", pcAddend, eAdd);
            checkOutput("pc_sel_branch", {31'd0, pcSel}, {31'd0, eSel});
            checkOutput("instr_out", instrOut, eInstr);
        end
        @(posedge clk);
    endtask

    task automatic runCycle(input logic [31:0] ins, input bit e, input bit r, input bit tk);
        applyStimulus(ins, e, r, tk);
        verifyCycle(1);
    endtask

    initial begin
        int s0;
        logic [31:0] w;
        logic [5:0]  op;

        // {ins, ext, res, taken, pc_write, pc_addend, pc_sel, instr_out}
        vecs[0]  = '{W_ADD, 0, 0, 0, 1, 32'd4, 0, W_ADD};
        vecs[1]  = '{W_LW,  0, 0, 0, 1, 32'd4, 0, W_LW};
        vecs[2]  = '{W_ADD, 0, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[3]  = '{W_BEQ, 0, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[4]  = '{W_ADD, 0, 0, 0, 1, 32'd4, 0, W_ADD};
        vecs[5]  = '{W_BEQ, 0, 0, 0, 1, 32'd4, 0, W_BEQ};
        vecs[6]  = '{W_ADD, 0, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[7]  = '{W_ADD, 0, 1, 1, 1, 32'd0, 1, 32'd0};
        vecs[8]  = '{W_ADD, 0, 1, 1, 1, 32'd4, 0, W_ADD};
        vecs[9]  = '{W_SW,  1, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[10] = '{W_SW,  0, 0, 0, 1, 32'd4, 0, W_SW};
        vecs[11] = '{W_ADD, 1, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[12] = '{W_ADD, 0, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[13] = '{W_ADD, 0, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[14] = '{W_ADD, 0, 0, 0, 1, 32'd4, 0, W_ADD};
        vecs[15] = '{W_BEQ, 0, 0, 0, 1, 32'd4, 0, W_BEQ};
        vecs[16] = '{W_ADD, 0, 1, 0, 1, 32'd4, 0, 32'd0};
        vecs[17] = '{W_ADD, 0, 0, 0, 1, 32'd4, 0, W_ADD};

        rst_n = 1'b0;
        instr = W_ADD;
        ext   = 1'b0;
        res   = 1'b1;
        taken = 1'b1;
        modelReset();
        #1;
        checkOutput("reset_pc_write", {31'd0, pcWrite}, 32'd0);
        checkOutput("reset_pc_addend", pcAddend, 32'd0);
        checkOutput("reset_instr_out", instrOut, 32'd0);
        checkOutput("reset_stall_cycles", {16'd0, stallCycles}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].ins, vecs[i].ext, vecs[i].res, vecs[i].tk);
            verifyCycle(0);
            // verifyCycle already clocked; outputs were sampled before the edge
        end
        applyStimulus(W_ADD, 0, 0, 0);
        checkOutput("table_stall_total", {16'd0, stallCycles}, 32'd9);
        verifyCycle(1);

        // Resolution on the same cycle the wait would time out: no error
        runCycle(W_BEQ, 0, 0, 0);
        for (int i = 0; i < BRT - 1; i++) runCycle(W_ADD, 0, 0, 0);
        applyStimulus(W_ADD, 0, 1, 0);
        checkOutput("late_resolve_pc_write", {31'd0, pcWrite}, 32'd1);
        checkOutput("late_resolve_addend", pcAddend, 32'd4);
        verifyCycle(1);
        applyStimulus(W_ADD, 0, 0, 0);
        checkOutput("late_resolve_no_err", {31'd0, brErr}, 32'd0);
        verifyCycle(1);

        // Timeout, with a resolution pulse swallowed by stall_ext first
        runCycle(W_BEQ, 0, 0, 0);
        runCycle(W_ADD, 1, 1, 1);
        for (int i = 0; i < BRT - 1; i++) runCycle(W_ADD, 0, 0, 0);
        applyStimulus(W_ADD, 0, 0, 0);
        checkOutput("timeout_pc_write", {31'd0, pcWrite}, 32'd1);
        checkOutput("timeout_addend", pcAddend, 32'd4);
        checkOutput("timeout_sel", {31'd0, pcSel}, 32'd0);
        verifyCycle(1);
        runCycle(W_ADD, 0, 0, 0);
        runCycle(W_LW, 0, 0, 0);
        applyStimulus(W_ADD, 0, 0, 0);
        checkOutput("timeout_err_sticky", {31'd0, brErr}, 32'd1);
        verifyCycle(1);
        runCycle(W_ADD, 0, 0, 0);

        // Load whose window is frozen for three cycles: five bubbles in total
        s0 = mStalls;
        runCycle(W_LW, 0, 0, 0);
        for (int i = 0; i < 3; i++) runCycle(W_BEQ, 1, 0, 0);
        runCycle(W_BEQ, 0, 0, 0);
        runCycle(W_BEQ, 0, 0, 0);
        applyStimulus(W_ADD, 0, 0, 0);
        checkOutput("mem_ext_stalls", {16'd0, stallCycles}, 32'(s0 + 5));
        checkOutput("mem_ext_resume", instrOut, W_ADD);
        verifyCycle(1);

        // Asynchronous reset in the middle of a branch wait
        runCycle(W_BEQ, 0, 0, 0);
        applyStimulus(W_ADD, 0, 1, 1);
        checkOutput("pre_reset_pc_write", {31'd0, pcWrite}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pc_write", {31'd0, pcWrite}, 32'd0);
        checkOutput("async_reset_sel", {31'd0, pcSel}, 32'd0);
        checkOutput("async_reset_addend", pcAddend, 32'd0);
        checkOutput("async_reset_err", {31'd0, brErr}, 32'd0);
        checkOutput("async_reset_stalls", {16'd0, stallCycles}, 32'd0);
        @(negedge clk);
        res   = 1'b0;
        taken = 1'b0;
        rst_n = 1'b1;
        modelReset();
        applyStimulus(W_ADD, 0, 0, 0);
        checkOutput("post_reset_run", instrOut, W_ADD);
        verifyCycle(1);
        runCycle(W_LW, 0, 0, 0);
        runCycle(W_LW, 0, 0, 0);
        runCycle(W_LW, 0, 0, 0);
        runCycle(W_LW, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 5))
                0, 1: op = 6'h00;
                2:    op = 6'h23;
                3:    op = 6'h2B;
                4:    op = 6'h04;
                default: op = 6'h08;
            endcase
            w = {op, 26'($urandom)};
            runCycle(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Table comparisons happen here so the vector loop stays readable
    int vecIdx = 0;
    always @(negedge clk) begin
        #1;
        if (rst_n && vecIdx < 18 && instr === vecs[vecIdx].ins && ext === vecs[vecIdx].ext
            && res === vecs[vecIdx].res && taken === vecs[vecIdx].tk && checks < 200) begin
            checkOutput("vec_pc_write", {31'd0, pcWrite}, {31'd0, vecs[vecIdx].pcw});
            checkOutput("vec_pc_addend", pcAddend, vecs[vecIdx].add);
            checkOutput("vec_pc_sel", {31'd0, pcSel}, {31'd0, vecs[vecIdx].sel});
            checkOutput("vec_instr_out", instrOut, vecs[vecIdx].out);
            vecIdx++;
        end
    end

endmodule
